// File: rtl/ascon_pack.sv
// Shared types, S-box tables and parameter checks for the ASCON substitution layer.
package ascon_pack;

  // Word x0 is index 0. Bit j of every word together forms column j.
  typedef logic [4:0][63:0] type_state;

  localparam logic [4:0] SBOX_FWD [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [4:0] SBOX_INV [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  function automatic bit nb_sbox_legal(input int n);
    return n inside {1, 2, 4, 8, 16, 32, 64};
  endfunction

endpackage

// File: rtl/sbox_5b_bidir.sv
// Combinational 5-bit ASCON S-box, forward or inverse selected per call.
module sbox_5b_bidir
  import ascon_pack::*;
(
  input  logic [4:0] data_i,
  input  logic       inv_i,
  output logic [4:0] data_o
);

  assign data_o = inv_i ? SBOX_INV[data_i] : SBOX_FWD[data_i];

endmodule

// File: rtl/substitution_layer_iter.sv
// Iterative ASCON substitution layer: NB_SBOX columns per cycle, 64/NB_SBOX cycles per layer.
module substitution_layer_iter
  import ascon_pack::*;
#(
  parameter int NB_SBOX = 8
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      valid_i,
  output logic      ready_o,
  input  logic      inv_i,
  input  type_state state_i,
  output logic      valid_o,
  input  logic      ready_i,
  output type_state state_o
);

  localparam int NB_STEP = 64 / NB_SBOX;
  localparam int CW      = (NB_STEP > 1) ? $clog2(NB_STEP) : 1;

  if (!nb_sbox_legal(NB_SBOX)) begin : g_bad_nb_sbox
    $error("substitution_layer_iter: NB_SBOX=%0d must be a power of two in 1..64", NB_SBOX);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t      state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic      mode_q;
  type_state work_q, work_nx;
  logic      last;
  logic [5:0] base;

  logic [4:0][NB_SBOX-1:0] col_q, col_d;
  logic [NB_SBOX-1:0][4:0] sb_in, sb_out;

  assign last = (cnt_q == CW'(NB_STEP - 1));
  assign base = 6'(32'(cnt_q) * 32'(NB_SBOX));

  // Column window of the current step, one slice per word.
  for (genvar b = 0; b < 5; b++) begin : g_word
    assign col_q[b] = work_q[b][base +: NB_SBOX];
  end

  for (genvar g = 0; g < NB_SBOX; g++) begin : g_lane
    assign sb_in[g] = {col_q[0][g], col_q[1][g], col_q[2][g], col_q[3][g], col_q[4][g]};

    sbox_5b_bidir u_sbox (
      .data_i (sb_in[g]),
      .inv_i  (mode_q),
      .data_o (sb_out[g])
    );

    for (genvar b = 0; b < 5; b++) begin : g_bit
      assign col_d[b][g] = sb_out[g][4-b];
    end
  end

  always_comb begin
    work_nx = work_q;
    for (int b = 0; b < 5; b++) work_nx[b][base +: NB_SBOX] = col_d[b];
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (valid_i) begin
          work_q <= state_i;
          mode_q <= inv_i;
          cnt_q  <= '0;
        end
        RUN: begin
          work_q <= work_nx;
          if (!last) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o = work_q;

endmodule

// File: tb/tb_substitution_layer_iter.sv
// Directed bench: three instances (NB_SBOX 1, 8, 64) driven in lockstep from shared inputs.
module tb_substitution_layer_iter;
  import ascon_pack::*;

  logic      clk = 1'b0;
  logic      rst, valid_i, inv_i, ready_i;
  type_state state_i;
  logic      rdy [3];
  logic      vld [3];
  type_state so  [3];

  int n_chk  = 0;
  int n_fail = 0;
  int exp_lat [3] = '{64, 8, 1};
  int lat [3];
  type_state res [3];

  always #5 clk = ~clk;

  substitution_layer_iter #(.NB_SBOX(1)) u_dut1 (
    .clock_i(clk), .reset_i(rst), .valid_i(valid_i), .ready_o(rdy[0]), .inv_i(inv_i),
    .state_i(state_i), .valid_o(vld[0]), .ready_i(ready_i), .state_o(so[0]));
  substitution_layer_iter #(.NB_SBOX(8)) u_dut8 (
    .clock_i(clk), .reset_i(rst), .valid_i(valid_i), .ready_o(rdy[1]), .inv_i(inv_i),
    .state_i(state_i), .valid_o(vld[1]), .ready_i(ready_i), .state_o(so[1]));
  substitution_layer_iter #(.NB_SBOX(64)) u_dut64 (
    .clock_i(clk), .reset_i(rst), .valid_i(valid_i), .ready_o(rdy[2]), .inv_i(inv_i),
    .state_i(state_i), .valid_o(vld[2]), .ready_i(ready_i), .state_o(so[2]));

  typedef struct {
    string     name;
    logic      inv;
    type_state in;
    type_state exp;
  } vec_t;

  vec_t vecs [7];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] B5   = 64'h0000_0000_0000_0020;
  localparam logic [63:0] P55  = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PAA  = 64'hAAAA_AAAA_AAAA_AAAA;

  function automatic type_state mk(input logic [63:0] x0, x1, x2, x3, x4);
    type_state s;
    s[0] = x0; s[1] = x1; s[2] = x2; s[3] = x3; s[4] = x4;
    return s;
  endfunction

  function automatic type_state rnd_state();
    type_state s;
    for (int b = 0; b < 5; b++) s[b] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Accepts one state on all instances and waits (bounded) until every one presents a result.
  task automatic run_layer(input type_state in, input logic inv);
    bit done;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("ready_before_accept[%0d]", d), 320'(rdy[d]), 320'(1));
    state_i = in; inv_i = inv; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; state_i = rnd_state(); inv_i = ~inv;
    lat = '{0, 0, 0};
    done = 1'b0;
    for (int c = 1; c <= 80 && !done; c++) begin
      @(posedge clk); #1;
      done = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (vld[d] && lat[d] == 0) lat[d] = c;
        if (lat[d] == 0) done = 1'b0;
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("latency[%0d]", d), 320'(lat[d]), 320'(exp_lat[d]));
      res[d] = so[d];
    end
  endtask

  task automatic release_out();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  initial begin
    type_state a, fwd, held;

    vecs[0] = '{"fwd_zero", 1'b0, mk(0, 0, 0, 0, 0),           mk(0, 0, ONES, 0, 0)};
    vecs[1] = '{"inv_zero", 1'b1, mk(0, 0, 0, 0, 0),           mk(ONES, 0, ONES, 0, 0)};
    vecs[2] = '{"fwd_col5", 1'b0, mk(B5, B5, B5, B5, B5),      mk(B5, 0, ONES, B5, B5)};
    vecs[3] = '{"fwd_ones", 1'b0, mk(ONES, ONES, ONES, ONES, ONES), mk(ONES, 0, ONES, ONES, ONES)};
    vecs[4] = '{"inv_ones", 1'b1, mk(ONES, ONES, ONES, ONES, ONES), mk(0, 0, 0, ONES, 0)};
    vecs[5] = '{"fwd_alt",  1'b0, mk(0, 0, 0, 0, P55),         mk(0, P55, PAA, P55, P55)};
    vecs[6] = '{"inv_alt",  1'b1, mk(0, 0, 0, 0, P55),         mk(ONES, P55, PAA, P55, 0)};

    rst = 1'b1; valid_i = 1'b0; inv_i = 1'b0; ready_i = 1'b0; state_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ready[%0d]", d), 320'(rdy[d]), 320'(1));
      check($sformatf("reset_valid[%0d]", d), 320'(vld[d]), 320'(0));
      check($sformatf("reset_state[%0d]", d), so[d], '0);
    end

    foreach (vecs[i]) begin
      run_layer(vecs[i].in, vecs[i].inv);
      for (int d = 0; d < 3; d++) check($sformatf("%s[%0d]", vecs[i].name, d), res[d], vecs[i].exp);
      release_out();
    end

    for (int it = 0; it < 150; it++) begin
      a = rnd_state();
      run_layer(a, 1'b0);
      fwd = res[1];
      release_out();
      run_layer(fwd, 1'b1);
      for (int d = 0; d < 3; d++) check($sformatf("roundtrip_%0d[%0d]", it, d), res[d], a);
      release_out();
    end

    // Results must hold under backpressure while new requests are ignored.
    run_layer(vecs[2].in, 1'b0);
    held = vecs[2].exp;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("bp_valid_%0d[%0d]", c, d), 320'(vld[d]), 320'(1));
        check($sformatf("bp_ready_%0d[%0d]", c, d), 320'(rdy[d]), 320'(0));
        check($sformatf("bp_state_%0d[%0d]", c, d), so[d], held);
      end
      valid_i = 1'b1; state_i = rnd_state(); inv_i = $urandom_range(0, 1) != 0;
    end
    @(negedge clk);
    valid_i = 1'b0;
    release_out();
    run_layer(vecs[5].in, vecs[5].inv);
    for (int d = 0; d < 3; d++) check($sformatf("after_bp[%0d]", d), res[d], vecs[5].exp);
    release_out();

    // Abort mid-layer: NB_SBOX=8 instance is at step 3 when reset is sampled.
    @(negedge clk);
    state_i = vecs[3].in; inv_i = 1'b0; valid_i = 1'b1;
    @(posedge clk); #1 valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("abort_valid[%0d]", d), 320'(vld[d]), 320'(0));
      check($sformatf("abort_ready[%0d]", d), 320'(rdy[d]), 320'(1));
      check($sformatf("abort_state[%0d]", d), so[d], '0);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) check($sformatf("abort_quiet_%0d[%0d]", c, d), 320'(vld[d]), 320'(0));
    end
    run_layer(vecs[1].in, vecs[1].inv);
    for (int d = 0; d < 3; d++) check($sformatf("after_abort[%0d]", d), res[d], vecs[1].exp);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
